pair_capture_fifo: RTL and testbench

Downstream consumer of the counter hierarchy's two offset outputs: every enabled cycle it captures the pair (data_a = counter+2 from module_a, data_b = counter+5 from module_b). It checks that data_b − data_a equals DELTA, and buffers the pair plus a mismatch flag in a small FIFO. A valid/ready port delivers the buffered pairs to a reader. Saturating counters record mismatches and dropped samples for bring-up and RyuSim regression checks.

---
 rtl/hier_pkg.sv | 16 +
 rtl/pair_fifo_core.sv | 64 ++++++
 rtl/pair_capture_fifo.sv | 83 ++++++++
 tb/tb_pair_capture_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hier_pkg.sv
// Shared constants for the counter hierarchy and its downstream consumers.
// Holds the sample offsets, the derived check delta and the saturating increment.
package hier_pkg;

  // module_a emits counter+2 and module_b emits counter+5, so their difference is 3.
  localparam int OFFSET_A      = 2;
  localparam int OFFSET_B      = 5;
  localparam int DELTA_DEFAULT = OFFSET_B - OFFSET_A;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pair_fifo_core.sv
// Small first-word-fall-through FIFO holding {mismatch, b, a} entries.
// Push and pop qualification is done by the caller.
module pair_fifo_core #(
  parameter  int EW    = 65,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared on reset so the head outputs never read X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/pair_capture_fifo.sv
// Captures (data_a, data_b) pairs, flags pairs whose difference is not DELTA,
// buffers them for a valid/ready reader and counts mismatches and drops.
module pair_capture_fifo
  import hier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int DELTA = DELTA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture_en,
  input  logic [WIDTH-1:0]       data_a,
  input  logic [WIDTH-1:0]       data_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_a,
  output logic [WIDTH-1:0]       out_b,
  output logic                   out_mismatch,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int EW = 2 * WIDTH + 1;

  logic [WIDTH-1:0] diff;
  logic             mismatch, push, pop, drop;
  logic [EW-1:0]    wdata, rdata;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Wraparound subtraction: a=FFFF_FFFF, b=2 still differs by 3.
  assign diff     = data_b - data_a;
  assign mismatch = (diff != WIDTH'(DELTA));

  assign pop   = !empty && out_ready;
  assign push  = capture_en && (!full || pop);
  assign drop  = capture_en && full && !pop;
  assign wdata = {mismatch, data_b, data_a};

  pair_fifo_core #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign {out_mismatch, out_b, out_a} = rdata;
  assign out_valid = !empty;

  // Mismatches count every failing capture, including ones that get dropped.
  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (capture_en && mismatch) mismatch_cnt_d = sat_inc(mismatch_cnt_q);
    if (drop)                   drop_cnt_d     = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      mismatch_cnt_q <= mismatch_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign mismatch_cnt = mismatch_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_pair_capture_fifo.sv
// Directed scoreboard bench for pair_capture_fifo: a queue model predicts
// every head entry, level, flag and counter value.
module tb_pair_capture_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] DELTA = 32'd3;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mm;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             capture_en = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic [WIDTH-1:0] data_b = '0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_mismatch, full, empty;
  logic [WIDTH-1:0] out_a, out_b;
  logic [2:0]       level;
  logic [15:0]      mismatch_cnt, drop_cnt;

  entry_t      sb[$];
  logic [15:0] expMm = '0;
  logic [15:0] expDrop = '0;
  int          checks = 0;
  int          failures = 0;

  pair_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELTA(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .capture_en   (capture_en),
    .data_a       (data_a),
    .data_b       (data_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_mismatch (out_mismatch),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .mismatch_cnt (mismatch_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard model.
  task automatic checkOutput();
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("empty", 64'(empty), 64'(sb.size() == 0));
    check("full", 64'(full), 64'(sb.size() == DEPTH));
    check("level", 64'(level), 64'(sb.size()));
    check("mismatch_cnt", 64'(mismatch_cnt), 64'(expMm));
    check("drop_cnt", 64'(drop_cnt), 64'(expDrop));
    if (sb.size() != 0) begin
      check("head_a", 64'(out_a), 64'(sb[0].a));
      check("head_b", 64'(out_b), 64'(sb[0].b));
      check("head_mm", 64'(out_mismatch), 64'(sb[0].mm));
    end
  endtask

  // Drive one cycle from a negedge, update the model at the posedge,
  // then optionally check at the following negedge.
  task automatic applyStimulus(input logic cap, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic rdy,
                               input bit doCheck);
    logic [WIDTH-1:0] d;
    bit doPop, doPush;
    entry_t e;
    capture_en = cap;
    data_a     = a;
    data_b     = b;
    out_ready  = rdy;
    d      = b - a;
    doPop  = (sb.size() != 0) && rdy;
    doPush = cap && ((sb.size() < DEPTH) || doPop);
    e.a  = a;
    e.b  = b;
    e.mm = (d != DELTA);
    @(posedge clk);
    if (doPop) void'(sb.pop_front());
    if (doPush) sb.push_back(e);
    if (cap && e.mm && expMm != 16'hFFFF) expMm++;
    if (cap && !doPush && expDrop != 16'hFFFF) expDrop++;
    @(negedge clk);
    capture_en = 1'b0;
    out_ready  = 1'b0;
    if (doCheck) checkOutput();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_out_mm", 64'(out_mismatch), 64'd0);
    checkOutput();
    reset = 1'b1;

    // In-sequence stream, fill to full
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 32'(c + 2), 32'(c + 5), 1'b0, 1'b1);
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd4);
    check("fill_mm_cnt", 64'(mismatch_cnt), 64'd0);

    // Overflow: three drops, head unchanged
    for (int c = 4; c < 7; c++) applyStimulus(1'b1, 32'(c + 2), 32'(c + 5), 1'b0, 1'b1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_head", 64'(out_a), 64'd2);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_a", 64'(out_a), 64'(i + 2));
      check("drain_mm", 64'(out_mismatch), 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Simultaneous push/pop while full
    for (int c = 10; c < 14; c++) applyStimulus(1'b1, 32'(c + 2), 32'(c + 5), 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd16, 32'd19, 1'b1, 1'b1);
    check("pp_level", 64'(level), 64'd4);
    check("pp_drop_cnt", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 4; i++) begin
      check("pp_drain_a", 64'(out_a), 64'(i + 13));
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    end

    // Mismatch and wraparound arithmetic
    applyStimulus(1'b1, 32'd10, 32'd20, 1'b0, 1'b1);
    check("mm_flag", 64'(out_mismatch), 64'd1);
    check("mm_cnt", 64'(mismatch_cnt), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
    check("wrap_flag", 64'(out_mismatch), 64'd0);
    check("wrap_cnt", 64'(mismatch_cnt), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);

    // Saturation with continuous popping
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 32'(i), 32'(i), 1'b1, (i % 4096) == 0);
    checkOutput();
    check("sat_cnt", 64'(mismatch_cnt), 64'hFFFF);
    applyStimulus(1'b1, 32'd1, 32'd9, 1'b1, 1'b1);
    check("sat_hold", 64'(mismatch_cnt), 64'hFFFF);
    check("sat_no_drop", 64'(drop_cnt), 64'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);

    // Reset mid-operation
    applyStimulus(1'b1, 32'd7, 32'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd8, 32'd11, 1'b0, 1'b1);
    check("pre_rst_level", 64'(level), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_mm_cnt", 64'(mismatch_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("mid_rst_out_a", 64'(out_a), 64'd0);
    sb.delete();
    expMm   = '0;
    expDrop = '0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'd2, 32'd5, 1'b0, 1'b1);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_a", 64'(out_a), 64'd2);
    check("post_rst_b", 64'(out_b), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
